memory_read_responder: RTL and testbench

- Responder end of the engine instruction-memory read interface; owns the instruction RAM.
- Arbitrates read requests from N engines round-robin and issues one RAM read at a time.
- Returns each word on a shared data bus together with a one-cycle broadcast of the address, so every engine cache can snoop the fill.
- Also accepts program-load writes from the host side.

---
 rtl/memory_read_responder_pkg.sv | 18 +
 rtl/memory_read_responder_if.sv | 30 +++
 rtl/memory_read_responder_rr_arbiter.sv | 37 +++
 rtl/memory_read_responder.sv | 118 +++++++++++
 tb/tb_memory_read_responder.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_read_responder_pkg.sv
// Shared types and helpers for the instruction-memory read responder.
package memory_read_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    // Ceiling log2 with a floor of 1 so that single-entry vectors keep a legal width.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        for (w = 1; (w < 32) && ((32'd1 << w) < value); w++) begin
        end
        return w;
    endfunction

endpackage

// File: rtl/memory_read_responder_if.sv
// Engine read-request / broadcast bus plus the host program-load port.
interface memory_read_responder_if #(
    parameter int unsigned N_PORTS           = 4,
    parameter int unsigned MEMORY_WIDTH      = 16,
    parameter int unsigned MEMORY_ADDR_WIDTH = 11
);
    logic [N_PORTS-1:0]                   req_valid;
    logic [N_PORTS*MEMORY_ADDR_WIDTH-1:0] req_addr;
    logic [N_PORTS-1:0]                   req_ready;
    logic [MEMORY_WIDTH-1:0]              data;
    logic                                 broadcast_valid;
    logic [MEMORY_ADDR_WIDTH-1:0]         broadcast_addr;
    logic                                 load_valid;
    logic [MEMORY_ADDR_WIDTH-1:0]         load_addr;
    logic [MEMORY_WIDTH-1:0]              load_data;
    logic                                 load_ready;
    logic                                 busy;

    // Engines and host loader side.
    modport master (
        output req_valid, req_addr, load_valid, load_addr, load_data,
        input  req_ready, data, broadcast_valid, broadcast_addr, load_ready, busy
    );

    // Responder side (owns the RAM).
    modport slave (
        input  req_valid, req_addr, load_valid, load_addr, load_data,
        output req_ready, data, broadcast_valid, broadcast_addr, load_ready, busy
    );
endinterface

// File: rtl/memory_read_responder_rr_arbiter.sv
// Round-robin arbiter: grants the first requester strictly after ptr, wrapping.
module rr_arbiter
    import memory_read_responder_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IDX_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);
    // Scan ptr+1 .. ptr+N (mod N) and take the first active request.
    always_comb begin
        logic        found;
        int unsigned idx;
        logic [IDX_W-1:0] idx_w;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            idx = 32'(ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_w = IDX_W'(idx);
            if (en && !found && req[idx_w]) begin
                found      = 1'b1;
                gnt[idx_w] = 1'b1;
                gnt_idx    = idx_w;
            end
        end
    end
endmodule

// File: rtl/memory_read_responder.sv
// Instruction-RAM owner: round-robin engine reads with snoopable broadcast, host program loads.
module memory_read_responder
    import memory_read_responder_pkg::*;
#(
    parameter int unsigned N_PORTS           = 4,
    parameter int unsigned MEMORY_WIDTH      = 16,
    parameter int unsigned MEMORY_ADDR_WIDTH = 11,
    parameter int unsigned READ_LATENCY      = 1
) (
    input logic                   clk,
    input logic                   rst,
    memory_read_responder_if.slave bus
);
    localparam int unsigned PTR_W = clog2(N_PORTS);
    localparam int unsigned CNT_W = clog2(READ_LATENCY);
    localparam int unsigned DEPTH = 2 ** MEMORY_ADDR_WIDTH;

    resp_state_t                  state;
    logic [PTR_W-1:0]             ptr;
    logic [CNT_W-1:0]             cnt;
    logic [MEMORY_ADDR_WIDTH-1:0] addr_q;
    logic [MEMORY_WIDTH-1:0]      ram [DEPTH];
    logic [MEMORY_WIDTH-1:0]      ram_word;
    logic [N_PORTS-1:0]           gnt;
    logic [PTR_W-1:0]             gnt_idx;
    logic                         grant_en;
    logic                         load_fire;
    logic [MEMORY_ADDR_WIDTH-1:0] port_addr [N_PORTS];

    // Unpack per-port addresses; decode handshake enables from state.
    always_comb begin
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            port_addr[i] = bus.req_addr[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
        end
        bus.load_ready = rst && (state == IDLE);
        bus.busy       = (state != IDLE);
        grant_en       = rst && (state == IDLE) && !bus.load_valid;
        load_fire      = bus.load_valid && bus.load_ready;
    end

    rr_arbiter #(.N(N_PORTS)) u_arb (
        .req     (bus.req_valid),
        .ptr     (ptr),
        .en      (grant_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Accept: the grant in IDLE, or snooping same-address requesters during RESP.
    always_comb begin
        bus.req_ready = '0;
        if (grant_en) begin
            bus.req_ready = gnt;
        end else if (rst && (state == RESP)) begin
            for (int unsigned i = 0; i < N_PORTS; i++) begin
                if ((PTR_W'(i) != ptr) && bus.req_valid[i] &&
                    (port_addr[i] == bus.broadcast_addr)) begin
                    bus.req_ready[i] = 1'b1;
                end
            end
        end
    end

    // Program-load write port; RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            ram[bus.load_addr] <= bus.load_data;
        end
    end

    // The final RAM stage is the data register itself; latency 2 adds one register ahead of it.
    if (READ_LATENCY > 1) begin : g_out_reg
        logic [MEMORY_WIDTH-1:0] rd_q;
        always_ff @(posedge clk) begin
            rd_q <= ram[addr_q];
        end
        always_comb ram_word = rd_q;
    end else begin : g_direct
        always_comb ram_word = ram[addr_q];
    end

    // Responder FSM: grant, count down the read latency, broadcast for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= IDLE;
            ptr                 <= '0;
            cnt                 <= '0;
            addr_q              <= '0;
            bus.broadcast_valid <= 1'b0;
            bus.broadcast_addr  <= '0;
            bus.data            <= '0;
        end else begin
            bus.broadcast_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_en && (|gnt)) begin
                        addr_q <= port_addr[gnt_idx];
                        ptr    <= gnt_idx;
                        cnt    <= CNT_W'(READ_LATENCY - 1);
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        bus.broadcast_valid <= 1'b1;
                        bus.broadcast_addr  <= addr_q;
                        bus.data            <= ram_word;
                        state               <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_read_responder.sv
// Self-checking bench for memory_read_responder (latency 1 and latency 2 instances).
`timescale 1ns/1ps
module tb_memory_read_responder;
    localparam int unsigned NP = 4;
    localparam int unsigned W  = 16;
    localparam int unsigned AW = 11;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    memory_read_responder_if #(.N_PORTS(NP), .MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW)) bus ();
    memory_read_responder_if #(.N_PORTS(NP), .MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW)) bus2 ();

    memory_read_responder #(.N_PORTS(NP), .MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW),
                            .READ_LATENCY(1)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    memory_read_responder #(.N_PORTS(NP), .MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW),
                            .READ_LATENCY(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int total = 0;
    int bad   = 0;
    logic [W-1:0] mem_model  [int];
    logic [W-1:0] mem_model2 [int];

    task automatic set_req(input int p, input logic v, input logic [AW-1:0] a);
        bus.req_valid[p]         = v;
        bus.req_addr[p*AW +: AW] = a;
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [W-1:0] d);
        int n = 0;
        @(negedge clk);
        bus.load_valid = 1'b1; bus.load_addr = a; bus.load_data = d;
        #1;
        while (!bus.load_ready && n < 20) begin @(negedge clk); #1; n++; end
        if (!bus.load_ready) begin
            total++; bad++;
            $display("FAIL load_timeout got=load_ready 0 exp=1 addr=%h", a);
        end
        mem_model[int'(a)] = d;
        @(posedge clk); #1;
        bus.load_valid = 1'b0;
    endtask

    task automatic load_word2(input logic [AW-1:0] a, input logic [W-1:0] d);
        int n = 0;
        @(negedge clk);
        bus2.load_valid = 1'b1; bus2.load_addr = a; bus2.load_data = d;
        #1;
        while (!bus2.load_ready && n < 20) begin @(negedge clk); #1; n++; end
        if (!bus2.load_ready) begin
            total++; bad++;
            $display("FAIL load2_timeout got=load_ready 0 exp=1 addr=%h", a);
        end
        mem_model2[int'(a)] = d;
        @(posedge clk); #1;
        bus2.load_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req_valid = '1; bus.req_addr = '0; bus.load_valid = 1'b1;
        bus.load_addr = '0; bus.load_data = '0;
        bus2.req_valid = '0; bus2.req_addr = '0; bus2.load_valid = 1'b0;
        bus2.load_addr = '0; bus2.load_data = '0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({bus.req_ready, bus.load_ready, bus.busy, bus.broadcast_valid} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=%b",
                     {bus.req_ready, bus.load_ready, bus.busy, bus.broadcast_valid}, 7'b0);
        end
        total++;
        if ({bus.broadcast_addr, bus.data} !== 27'h0) begin
            bad++;
            $display("FAIL reset_bus got=%h exp=0", {bus.broadcast_addr, bus.data});
        end
        total++;
        if ({bus2.busy, bus2.broadcast_valid, bus2.data} !== 18'h0) begin
            bad++;
            $display("FAIL reset_dut2 got=%h exp=0", {bus2.busy, bus2.broadcast_valid, bus2.data});
        end
        bus.req_valid = '0; bus.load_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk); set_req(0, 1'b1, 11'd5); #1;
        total++;
        if (bus.req_ready !== 4'b0001) begin
            bad++; $display("FAIL single_grant got=%b exp=0001", bus.req_ready);
        end
        @(negedge clk); set_req(0, 1'b0, 11'd0); #1;
        total++;
        if ({bus.busy, bus.req_ready, bus.load_ready, bus.broadcast_valid} !== 7'b1000000) begin
            bad++;
            $display("FAIL single_wait got=%b exp=1000000",
                     {bus.busy, bus.req_ready, bus.load_ready, bus.broadcast_valid});
        end
        @(negedge clk); #1;
        total++;
        if ({bus.broadcast_valid, bus.broadcast_addr, bus.data} !== {1'b1, 11'd5, 16'hBEEF}) begin
            bad++;
            $display("FAIL single_bcast got=%b/%h/%h exp=1/005/beef",
                     bus.broadcast_valid, bus.broadcast_addr, bus.data);
        end
        @(negedge clk); #1;
        total++;
        if ({bus.broadcast_valid, bus.busy, bus.data} !== {2'b00, 16'hBEEF}) begin
            bad++;
            $display("FAIL single_hold got=%b/%b/%h exp=0/0/beef",
                     bus.broadcast_valid, bus.busy, bus.data);
        end
    endtask

    task automatic test_round_robin();
        int g_port[$];
        int g_cyc[$];
        int exp_order[5] = '{1, 2, 3, 0, 1};
        int n = 0;
        int idx;
        pulse_reset();
        @(negedge clk);
        for (int i = 0; i < NP; i++) set_req(i, 1'b1, AW'(32 + i));
        while (g_port.size() < 5 && n < 60) begin
            #1;
            if (!bus.busy && bus.req_ready != '0) begin
                idx = -1;
                for (int i = 0; i < NP; i++) if (bus.req_ready[i]) idx = i;
                g_port.push_back(idx);
                g_cyc.push_back(n);
            end
            @(negedge clk); n++;
        end
        bus.req_valid = '0;
        if (g_port.size() < 5) begin
            total++; bad++;
            $display("FAIL rr_timeout got=%0d grants exp=5", g_port.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                total++;
                if (g_port[k] !== exp_order[k]) begin
                    bad++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, g_port[k], exp_order[k]);
                end
            end
            for (int k = 1; k < 5; k++) begin
                total++;
                if (g_cyc[k] - g_cyc[k-1] !== 3) begin
                    bad++; $display("FAIL rr_spacing[%0d] got=%0d exp=3", k, g_cyc[k] - g_cyc[k-1]);
                end
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_coalesce();
        int extra = 0;
        @(negedge clk); set_req(0, 1'b1, 11'h10); #1;
        total++;
        if (bus.req_ready !== 4'b0001) begin
            bad++; $display("FAIL coal_grant got=%b exp=0001", bus.req_ready);
        end
        @(negedge clk); set_req(0, 1'b0, 11'h0); set_req(2, 1'b1, 11'h10); #1;
        total++;
        if (bus.req_ready !== 4'b0000) begin
            bad++; $display("FAIL coal_wait got=%b exp=0000", bus.req_ready);
        end
        @(negedge clk); set_req(1, 1'b1, 11'h11); #1;
        total++;
        if ({bus.broadcast_valid, bus.broadcast_addr, bus.data, bus.req_ready} !==
            {1'b1, 11'h10, mem_model[16], 4'b0100}) begin
            bad++;
            $display("FAIL coal_resp got=%b/%h/%h/%b exp=1/010/%h/0100", bus.broadcast_valid,
                     bus.broadcast_addr, bus.data, bus.req_ready, mem_model[16]);
        end
        @(negedge clk); set_req(2, 1'b0, 11'h0); #1;
        total++;
        if (bus.req_ready !== 4'b0010) begin
            bad++; $display("FAIL coal_next_grant got=%b exp=0010", bus.req_ready);
        end
        @(negedge clk); set_req(1, 1'b0, 11'h0);
        for (int k = 0; k < 6; k++) begin
            #1;
            if (bus.req_ready != '0) extra++;
            if (bus.broadcast_valid && bus.broadcast_addr !== 11'h11) extra++;
            @(negedge clk);
        end
        total++;
        if (extra !== 0) begin
            bad++; $display("FAIL coal_no_reread got=%0d extra events exp=0", extra);
        end
    endtask

    task automatic test_load_priority();
        @(negedge clk); set_req(1, 1'b1, 11'd7); #1;
        total++;
        if (bus.req_ready !== 4'b0010) begin
            bad++; $display("FAIL lp_grant got=%b exp=0010", bus.req_ready);
        end
        @(negedge clk); set_req(1, 1'b0, 11'd0);
        bus.load_valid = 1'b1; bus.load_addr = 11'd7; bus.load_data = 16'h1234; #1;
        total++;
        if (bus.load_ready !== 1'b0) begin
            bad++; $display("FAIL lp_stall_wait got=%b exp=0", bus.load_ready);
        end
        @(negedge clk); #1;
        total++;
        if ({bus.load_ready, bus.broadcast_valid, bus.data} !== {2'b01, mem_model[7]}) begin
            bad++;
            $display("FAIL lp_stall_resp got=%b/%b/%h exp=0/1/%h",
                     bus.load_ready, bus.broadcast_valid, bus.data, mem_model[7]);
        end
        @(negedge clk); set_req(1, 1'b1, 11'd7); #1;
        total++;
        if ({bus.load_ready, bus.req_ready} !== 5'b10000) begin
            bad++; $display("FAIL lp_load_wins got=%b exp=10000", {bus.load_ready, bus.req_ready});
        end
        mem_model[7] = 16'h1234;
        @(negedge clk); bus.load_valid = 1'b0; #1;
        total++;
        if (bus.req_ready !== 4'b0010) begin
            bad++; $display("FAIL lp_read_next got=%b exp=0010", bus.req_ready);
        end
        @(negedge clk); set_req(1, 1'b0, 11'd0);
        @(negedge clk); #1;
        total++;
        if ({bus.broadcast_valid, bus.data} !== {1'b1, 16'h1234}) begin
            bad++; $display("FAIL lp_readback got=%b/%h exp=1/1234", bus.broadcast_valid, bus.data);
        end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk); set_req(3, 1'b1, 11'd5); #1;
        total++;
        if (bus.req_ready !== 4'b1000) begin
            bad++; $display("FAIL rmw_grant got=%b exp=1000", bus.req_ready);
        end
        @(negedge clk); set_req(3, 1'b0, 11'd0); #1;
        rst = 1'b0; #1;
        total++;
        if ({bus.req_ready, bus.load_ready, bus.busy, bus.broadcast_valid,
             bus.broadcast_addr, bus.data} !== 34'h0) begin
            bad++;
            $display("FAIL rmw_reset_vals got=%b/%b/%b/%b/%h/%h exp=0", bus.req_ready, bus.load_ready,
                     bus.busy, bus.broadcast_valid, bus.broadcast_addr, bus.data);
        end
        @(negedge clk); rst = 1'b1; set_req(3, 1'b1, 11'd5); #1;
        total++;
        if ({bus.broadcast_valid, bus.req_ready} !== 5'b01000) begin
            bad++;
            $display("FAIL rmw_discard_regrant got=%b exp=01000", {bus.broadcast_valid, bus.req_ready});
        end
        @(negedge clk); set_req(3, 1'b0, 11'd0);
        @(negedge clk); #1;
        total++;
        if ({bus.broadcast_valid, bus.broadcast_addr, bus.data} !== {1'b1, 11'd5, 16'hBEEF}) begin
            bad++;
            $display("FAIL rmw_served got=%b/%h/%h exp=1/005/beef",
                     bus.broadcast_valid, bus.broadcast_addr, bus.data);
        end
    endtask

    task automatic test_addr_wrap();
        @(negedge clk); set_req(2, 1'b1, 11'h7FF); #1;
        @(negedge clk); set_req(2, 1'b0, 11'h0);
        @(negedge clk); #1;
        total++;
        if ({bus.broadcast_valid, bus.broadcast_addr, bus.data} !== {1'b1, 11'h7FF, mem_model[2047]}) begin
            bad++;
            $display("FAIL wrap_top got=%b/%h/%h exp=1/7ff/%h", bus.broadcast_valid,
                     bus.broadcast_addr, bus.data, mem_model[2047]);
        end
    endtask

    task automatic test_latency2();
        int g_port[$];
        int g_cyc[$];
        int exp_order[5] = '{1, 2, 3, 0, 1};
        int n = 0;
        int idx;
        int first_b = -1;
        logic [AW-1:0] b_addr = '0;
        logic [W-1:0]  b_data = '0;
        for (int i = 0; i < NP; i++) load_word2(AW'(32 + i), W'(16'h5A00 + i));
        @(negedge clk);
        bus2.req_valid = '1;
        for (int i = 0; i < NP; i++) bus2.req_addr[i*AW +: AW] = AW'(32 + i);
        while (g_port.size() < 5 && n < 80) begin
            #1;
            if (!bus2.busy && bus2.req_ready != '0) begin
                idx = -1;
                for (int i = 0; i < NP; i++) if (bus2.req_ready[i]) idx = i;
                g_port.push_back(idx);
                g_cyc.push_back(n);
            end
            if (bus2.broadcast_valid && first_b < 0) begin
                first_b = n; b_addr = bus2.broadcast_addr; b_data = bus2.data;
            end
            @(negedge clk); n++;
        end
        bus2.req_valid = '0;
        if (g_port.size() < 5) begin
            total++; bad++;
            $display("FAIL l2_timeout got=%0d grants exp=5", g_port.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                total++;
                if (g_port[k] !== exp_order[k]) begin
                    bad++; $display("FAIL l2_order[%0d] got=%0d exp=%0d", k, g_port[k], exp_order[k]);
                end
            end
            for (int k = 1; k < 5; k++) begin
                total++;
                if (g_cyc[k] - g_cyc[k-1] !== 4) begin
                    bad++; $display("FAIL l2_spacing[%0d] got=%0d exp=4", k, g_cyc[k] - g_cyc[k-1]);
                end
            end
            total++;
            if (first_b !== g_cyc[0] + 3 || b_addr !== 11'd33 || b_data !== mem_model2[33]) begin
                bad++;
                $display("FAIL l2_first_bcast got=cyc%0d/%h/%h exp=cyc%0d/021/%h",
                         first_b, b_addr, b_data, g_cyc[0] + 3, mem_model2[33]);
            end
        end
        repeat (5) @(negedge clk);
    endtask

    // Transaction-level reference: a read answered RL+1 cycles after its grant, then one idle slot.
    task automatic test_random();
        logic          rv [NP];
        logic [AW-1:0] ra [NP];
        logic          lv = 1'b0;
        logic [AW-1:0] la = '0;
        logic [W-1:0]  ld = '0;
        bit            pending = 1'b0;
        int            pend_g = 0;
        logic [AW-1:0] pend_addr = '0;
        int            bcast_at = 0;
        int            last_g = 0;
        int            j;
        logic [NP-1:0] exp_ready;
        logic          exp_bv, exp_lr, exp_busy;
        logic [W-1:0]  last_data = '0;
        for (int i = 0; i < NP; i++) begin rv[i] = 1'b0; ra[i] = '0; end
        for (int k = 0; k < 8; k++) load_word(AW'(64 + k), W'($urandom));
        pulse_reset();
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NP; i++) begin
                if (!rv[i] && $urandom_range(0, 3) == 0) begin
                    rv[i] = 1'b1; ra[i] = AW'(64 + $urandom_range(0, 7));
                end
                set_req(i, rv[i], ra[i]);
            end
            if (!lv && $urandom_range(0, 9) == 0) begin
                lv = 1'b1; la = AW'(64 + $urandom_range(0, 7)); ld = W'($urandom);
            end
            bus.load_valid = lv; bus.load_addr = la; bus.load_data = ld;
            #1;
            exp_ready = '0; exp_bv = 1'b0; exp_lr = 1'b0; exp_busy = 1'b1;
            if (pending && cyc == bcast_at) begin
                exp_bv    = 1'b1;
                last_data = mem_model[int'(pend_addr)];
                for (int i = 0; i < NP; i++)
                    if (i != pend_g && rv[i] && ra[i] == pend_addr) exp_ready[i] = 1'b1;
                pending = 1'b0;
            end else if (!pending) begin
                exp_busy = 1'b0; exp_lr = 1'b1;
                if (!lv) begin
                    for (int k = NP; k >= 1; k--) begin
                        j = (last_g + k) % NP;
                        if (rv[j]) pend_g = j;
                    end
                    if (rv[pend_g] && (pend_g != last_g || rv.sum() with (int'(item)) > 0)) begin
                        if (rv[pend_g]) begin
                            exp_ready[pend_g] = 1'b1;
                            pending = 1'b1; pend_addr = ra[pend_g];
                            bcast_at = cyc + 2; last_g = pend_g;
                        end
                    end
                end
            end
            total++;
            if ({bus.req_ready, bus.busy, bus.load_ready, bus.broadcast_valid} !==
                {exp_ready, exp_busy, exp_lr, exp_bv}) begin
                bad++;
                $display("FAIL rand_ctrl cyc=%0d got=%b/%b/%b/%b exp=%b/%b/%b/%b", cyc,
                         bus.req_ready, bus.busy, bus.load_ready, bus.broadcast_valid,
                         exp_ready, exp_busy, exp_lr, exp_bv);
            end
            total++;
            if (bus.data !== last_data || (exp_bv && bus.broadcast_addr !== pend_addr)) begin
                bad++;
                $display("FAIL rand_data cyc=%0d got=%h/%h exp=%h/%h", cyc,
                         bus.data, bus.broadcast_addr, last_data, pend_addr);
            end
            for (int i = 0; i < NP; i++) if (exp_ready[i]) rv[i] = 1'b0;
            if (lv && exp_lr) begin mem_model[int'(la)] = ld; lv = 1'b0; end
        end
        @(negedge clk);
        bus.req_valid = '0; bus.load_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        load_word(11'd5, 16'hBEEF);
        load_word(11'd7, 16'h0707);
        load_word(11'h10, 16'h1010);
        load_word(11'h11, 16'h1111);
        for (int i = 0; i < NP; i++) load_word(AW'(32 + i), W'(16'hC000 + i));
        load_word(11'h7FF, 16'hA5C3);
        test_single();
        test_round_robin();
        test_coalesce();
        test_load_priority();
        test_reset_mid_wait();
        test_addr_wrap();
        test_latency2();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
